output_control: RTL and testbench

- Return-path counterpart of the serial operand loader: collects result rows from the N-wide systolic array and streams them off-chip on one serial pin.
- Each `res_valid` strobe captures one row of N results into a WORD-deep internal buffer.
- An unload request serializes the buffer LSB-first: column 0 first, then row by row, at one bit per clock.
- A held-high enable paces the stream, mirroring the load-side handshake.

---
 rtl/output_control.sv | 135 +++++++++++++
 tb/tb_output_control.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/output_control.sv
`default_nettype none
// output_control: buffers result rows from the systolic array and streams them
// LSB-first on one serial pin (column 0 first, row by row), paced by unload_en.
module output_control #(
  parameter int D_W   = 8,
  parameter int N     = 2,
  parameter int WORD  = 8,
  parameter int OUT_W = 2 * D_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N*OUT_W-1:0] res_in_flat,
  input  logic               res_valid,
  input  logic               unload_en,
  output logic               data_out,
  output logic               out_valid,
  output logic               done,
  output logic               full,
  output logic               busy
);

  localparam int RW = $clog2(WORD + 1);
  localparam int AW = (WORD > 1) ? $clog2(WORD) : 1;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int BW = (OUT_W > 1) ? $clog2(OUT_W) : 1;

  localparam logic [RW-1:0] ROW_MAX  = RW'(WORD);
  localparam logic [RW-1:0] ROW_LAST = RW'(WORD - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(N - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(OUT_W - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t         state;
  state_t         state_next;
  logic [RW-1:0]  row_count;
  logic [RW-1:0]  rd_row;
  logic [CW-1:0]  rd_col;
  logic [BW-1:0]  bit_cnt;
  logic [OUT_W-1:0] mem [WORD][N];

  logic capture;
  logic last_bit;
  logic cur_bit;

  assign cur_bit = mem[rd_row[AW-1:0]][rd_col][bit_cnt];
  assign busy    = (state != IDLE);

  always_comb begin
    capture    = (state == IDLE) && res_valid && (row_count < ROW_MAX);
    last_bit   = (rd_row == row_count - RW'(1)) && (rd_col == COL_LAST) &&
                 (bit_cnt == BIT_LAST);
    state_next = state;
    case (state)
      // A row captured on this same edge counts toward a non-empty buffer.
      IDLE:    if (unload_en && ((row_count != '0) || res_valid)) state_next = SHIFT;
      SHIFT:   if (unload_en && last_bit) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (capture) begin
      for (int c = 0; c < N; c++) begin
        mem[row_count[AW-1:0]][c] <= res_in_flat[c*OUT_W +: OUT_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      row_count <= '0;
      rd_row    <= '0;
      rd_col    <= '0;
      bit_cnt   <= '0;
      data_out  <= 1'b0;
      out_valid <= 1'b0;
      done      <= 1'b0;
      full      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (capture) begin
        row_count <= row_count + RW'(1);
        full      <= (row_count == ROW_LAST);
      end
      case (state)
        IDLE: out_valid <= 1'b0;
        SHIFT: begin
          if (unload_en) begin
            data_out  <= cur_bit;
            out_valid <= 1'b1;
            // Pointers stop on the final bit; DONE clears them.
            if (!last_bit) begin
              if (bit_cnt == BIT_LAST) begin
                bit_cnt <= '0;
                if (rd_col == COL_LAST) begin
                  rd_col <= '0;
                  rd_row <= rd_row + RW'(1);
                end else begin
                  rd_col <= rd_col + CW'(1);
                end
              end else begin
                bit_cnt <= bit_cnt + BW'(1);
              end
            end
          end else begin
            out_valid <= 1'b0;
          end
        end
        DONE: begin
          done      <= 1'b1;
          out_valid <= 1'b0;
          row_count <= '0;
          rd_row    <= '0;
          rd_col    <= '0;
          bit_cnt   <= '0;
          full      <= 1'b0;
        end
        default: out_valid <= 1'b0;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_output_control.sv
`default_nettype none
// tb_output_control: directed vectors with hand-computed expectations for output_control.
module tb_output_control;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] res_in_flat;
  logic        res_valid;
  logic        unload_en;
  logic        data_out;
  logic        out_valid;
  logic        done;
  logic        full;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  logic [255:0] cap_bits;
  int           cap_cnt;
  int           first_cyc;
  int           last_cyc;
  int           done_cyc;
  int           pause_viol;
  bit           done_seen;

  logic [31:0] rows8 [8] = '{32'h0001_8000, 32'h1111_2222, 32'hA5A5_5A5A, 32'h0F0F_F0F0,
                             32'h8001_7FFE, 32'hCAFE_BABE, 32'hFFFF_0000, 32'h0123_4567};

  output_control #(.D_W(8), .N(2), .WORD(8), .OUT_W(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .res_in_flat (res_in_flat),
    .res_valid   (res_valid),
    .unload_en   (unload_en),
    .data_out    (data_out),
    .out_valid   (out_valid),
    .done        (done),
    .full        (full),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic capture_row(input logic [31:0] row);
    res_in_flat = row;
    res_valid   = 1'b1;
    tick();
    res_valid   = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_data_out"},  {31'd0, data_out},  32'd0);
    check({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
    check({tag, "_done"},      {31'd0, done},      32'd0);
    check({tag, "_full"},      {31'd0, full},      32'd0);
    check({tag, "_busy"},      {31'd0, busy},      32'd0);
  endtask

  // Holds unload_en high until done, recording every valid bit in order.
  task automatic run_unload(input int pause_at, input int pause_len, input bit inj);
    int cyc;
    cyc        = 0;
    cap_bits   = '0;
    cap_cnt    = 0;
    first_cyc  = -1;
    last_cyc   = -1;
    done_cyc   = -1;
    pause_viol = 0;
    done_seen  = 1'b0;
    unload_en  = 1'b1;
    while (!done_seen && cyc < 1000) begin
      tick();
      cyc++;
      res_valid = inj;
      if (done) begin
        done_seen = 1'b1;
        done_cyc  = cyc;
      end
      if (out_valid) begin
        if (first_cyc < 0) first_cyc = cyc;
        last_cyc = cyc;
        if (cap_cnt < 256) cap_bits[cap_cnt] = data_out;
        cap_cnt++;
        if (pause_len > 0 && cap_cnt == pause_at + 1) begin
          unload_en = 1'b0;
          for (int p = 0; p < pause_len; p++) begin
            tick();
            cyc++;
            if (out_valid) pause_viol++;
          end
          unload_en = 1'b1;
        end
      end
    end
    unload_en = 1'b0;
    res_valid = 1'b0;
    check("unload_done_seen", {31'd0, done_seen}, 32'd1);
  endtask

  initial begin
    int viol;
    rst         = 1'b0;
    res_in_flat = '0;
    res_valid   = 1'b0;
    unload_en   = 1'b0;
    repeat (3) tick();
    check_idle_outputs("reset");
    rst = 1'b1;
    tick();

    // 1: single row
    capture_row({16'hBEEF, 16'h1234});
    check("s1_full_after_capture", {31'd0, full}, 32'd0);
    run_unload(-1, 0, 1'b0);
    check("s1_bit_count", cap_cnt, 32'd32);
    check("s1_bits", cap_bits[31:0], 32'hBEEF_1234);
    check("s1_first_latency", first_cyc, 32'd2);
    check("s1_done_after_last", done_cyc - last_cyc, 32'd1);
    check("s1_busy_at_done", {31'd0, busy}, 32'd0);
    tick();
    check("s1_done_one_cycle", {31'd0, done}, 32'd0);
    check("s1_busy_after", {31'd0, busy}, 32'd0);

    // 2: fill, overflow, unload
    for (int i = 0; i < 8; i++) begin
      check("s2_full_before_row", {31'd0, full}, 32'd0);
      capture_row(rows8[i]);
    end
    check("s2_full_after_8", {31'd0, full}, 32'd1);
    capture_row(32'hDEAD_DEAD);
    check("s2_full_after_drop", {31'd0, full}, 32'd1);
    check("s2_busy_idle", {31'd0, busy}, 32'd0);
    run_unload(-1, 0, 1'b0);
    check("s2_bit_count", cap_cnt, 32'd256);
    for (int i = 0; i < 8; i++) check("s2_row_bits", cap_bits[i*32 +: 32], rows8[i]);
    check("s2_full_after_done", {31'd0, full}, 32'd0);
    tick();

    // 3: pause after bit 5
    capture_row({16'hBEEF, 16'h1234});
    run_unload(5, 3, 1'b0);
    check("s3_pause_no_valid", pause_viol, 32'd0);
    check("s3_bit_count", cap_cnt, 32'd32);
    check("s3_bits", cap_bits[31:0], 32'hBEEF_1234);
    check("s3_done_after_last", done_cyc - last_cyc, 32'd1);
    tick();

    // 4: empty unload after reset
    rst = 1'b0;
    tick();
    rst = 1'b1;
    unload_en = 1'b1;
    viol = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (out_valid || done || busy) viol++;
    end
    unload_en = 1'b0;
    check("s4_empty_no_activity", viol, 32'd0);

    // 5a: capture and unload in the same IDLE cycle
    res_in_flat = 32'hCAFE_0F0F;
    res_valid   = 1'b1;
    run_unload(-1, 0, 1'b0);
    check("s5a_bit_count", cap_cnt, 32'd32);
    check("s5a_bits", cap_bits[31:0], 32'hCAFE_0F0F);
    check("s5a_first_latency", first_cyc, 32'd2);
    tick();

    // 5b: res_valid held during SHIFT/DONE is dropped
    capture_row(32'h1111_2222);
    res_in_flat = 32'h9999_9999;
    run_unload(-1, 0, 1'b1);
    check("s5b_bit_count", cap_cnt, 32'd32);
    check("s5b_bits", cap_bits[31:0], 32'h1111_2222);
    check("s5b_full_after", {31'd0, full}, 32'd0);
    unload_en = 1'b1;
    viol = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (out_valid || busy) viol++;
    end
    unload_en = 1'b0;
    check("s5b_row_count_zero", viol, 32'd0);
    tick();

    // 6: reset at bit 10
    capture_row({16'hBEEF, 16'h1234});
    unload_en = 1'b1;
    cap_cnt = 0;
    for (int i = 0; i < 100 && cap_cnt < 10; i++) begin
      tick();
      if (out_valid) cap_cnt++;
    end
    check("s6_reached_bit10", cap_cnt, 32'd10);
    rst = 1'b0;
    tick();
    check_idle_outputs("s6_reset");
    rst       = 1'b1;
    unload_en = 1'b0;
    tick();
    check("s6_idle_busy", {31'd0, busy}, 32'd0);
    capture_row(32'h0000_0001);
    run_unload(-1, 0, 1'b0);
    check("s6_bit_count", cap_cnt, 32'd32);
    check("s6_bits", cap_bits[31:0], 32'h0000_0001);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
